// File: rtl/clk_divider_pkg.sv
// Shared constants and sizing helper for the integer clock divider.
package clk_divider_pkg;

  localparam int unsigned DEF_CLK_DIVISOR = 50000;

  // Half-period counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned divisor);
    int unsigned half;
    half = divisor / 2;
    if (half <= 1) return 1;
    return $clog2(half);
  endfunction

endpackage

// File: rtl/clk_divider.sv
// Integer clock divider: 50%-duty CLK_OUT with a period of DIVISOR CLK cycles.
// Optional TICK pulse output when CLK_DIVIDER_TICK_EN is defined.
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int unsigned DIVISOR = DEF_CLK_DIVISOR
) (
  input  logic CLK,
  input  logic RST,
  input  logic CE,
`ifdef CLK_DIVIDER_TICK_EN
  output logic TICK,
`endif
  output logic CLK_OUT
);

  localparam int unsigned HALF  = DIVISOR / 2;
  localparam int unsigned CNT_W = cnt_width(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF - 1);

  generate
    if (DIVISOR < 2 || (DIVISOR % 2) != 0) begin : g_bad_divisor
      $error("clk_divider: DIVISOR must be even and >= 2");
    end
  endgenerate

  logic [CNT_W-1:0] cnt;
  logic             wrap_c;

  // End of a half period.
  always_comb begin
    wrap_c = 1'b0;
    if (cnt == CNT_MAX) wrap_c = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= '0;
      CLK_OUT <= 1'b0;
    end else if (CE) begin
      if (wrap_c) begin
        cnt     <= '0;
        CLK_OUT <= ~CLK_OUT;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef CLK_DIVIDER_TICK_EN
  // One-cycle pulse aligned with the first high cycle of CLK_OUT.
  always_ff @(posedge CLK) begin
    if (RST) TICK <= 1'b0;
    else     TICK <= CE & wrap_c & ~CLK_OUT;
  end
`endif

endmodule

// File: tb/tb_clk_divider.sv
// Directed self-checking bench for clk_divider at several DIVISOR values.
`timescale 1ns/1ps
module tb_clk_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4 = 1'b1, ce4 = 1'b1, out4;
  logic rst2 = 1'b1, ce2 = 1'b1, out2;
  logic rst8 = 1'b1, ce8 = 1'b1, out8;
  logic rst6 = 1'b1, ce6 = 1'b1, out6;
  logic rstb = 1'b1, ceb = 1'b1, outb;
`ifdef CLK_DIVIDER_TICK_EN
  logic tick4, tick2, tick8, tick6, tickb;
`endif

  int checks = 0;
  int failures = 0;

  clk_divider #(.DIVISOR(4)) dut4 (.CLK(clk), .RST(rst4), .CE(ce4),
`ifdef CLK_DIVIDER_TICK_EN
    .TICK(tick4),
`endif
    .CLK_OUT(out4));
  clk_divider #(.DIVISOR(2)) dut2 (.CLK(clk), .RST(rst2), .CE(ce2),
`ifdef CLK_DIVIDER_TICK_EN
    .TICK(tick2),
`endif
    .CLK_OUT(out2));
  clk_divider #(.DIVISOR(8)) dut8 (.CLK(clk), .RST(rst8), .CE(ce8),
`ifdef CLK_DIVIDER_TICK_EN
    .TICK(tick8),
`endif
    .CLK_OUT(out8));
  clk_divider #(.DIVISOR(6)) dut6 (.CLK(clk), .RST(rst6), .CE(ce6),
`ifdef CLK_DIVIDER_TICK_EN
    .TICK(tick6),
`endif
    .CLK_OUT(out6));
  clk_divider dutb (.CLK(clk), .RST(rstb), .CE(ceb),
`ifdef CLK_DIVIDER_TICK_EN
    .TICK(tickb),
`endif
    .CLK_OUT(outb));

  // Edge counter and first rise/fall capture for the default-DIVISOR instance.
  int big_edges = 0;
  int big_rise = -1;
  int big_fall = -1;
  always @(posedge clk) begin
    if (rstb) big_edges = 0;
    else      big_edges = big_edges + 1;
  end
  always @(negedge clk) begin
    if (!rstb) begin
      if (outb && big_rise < 0) big_rise = big_edges;
      if (!outb && big_rise >= 0 && big_fall < 0) big_fall = big_edges;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [5:0] exp4_out, exp4_cnt0, exp4_tick;
    logic [3:0] exp2_out;

    // Reset all instances for 3 cycles with CE high.
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst4_out_%0d", i), 32'(out4), 32'd0);
      check($sformatf("rst4_cnt_%0d", i), 32'(dut4.cnt), 32'd0);
`ifdef CLK_DIVIDER_TICK_EN
      check($sformatf("rst4_tick_%0d", i), 32'(tick4), 32'd0);
`endif
    end
    rst4 = 1'b0;
    rstb = 1'b0;

    // DIVISOR=4: rises on edge 2, falls on 4, rises on 6 (bit i = edge i+1).
    exp4_out  = 6'b100110;
    exp4_cnt0 = 6'b101010;
    exp4_tick = 6'b100010;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("div4_out_e%0d", i + 1), 32'(out4), 32'(exp4_out[i]));
      check($sformatf("div4_cnt_e%0d", i + 1), 32'(dut4.cnt), 32'(exp4_cnt0[i] ? 0 : 1));
`ifdef CLK_DIVIDER_TICK_EN
      check($sformatf("div4_tick_e%0d", i + 1), 32'(tick4), 32'(exp4_tick[i]));
`endif
    end
    // CE low freezes output and counter, TICK stays low.
    ce4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("div4_hold_out_%0d", i), 32'(out4), 32'd1);
      check($sformatf("div4_hold_cnt_%0d", i), 32'(dut4.cnt), 32'd0);
`ifdef CLK_DIVIDER_TICK_EN
      check($sformatf("div4_hold_tick_%0d", i), 32'(tick4), 32'd0);
`endif
    end

    // DIVISOR=2: toggles every edge.
    rst2 = 1'b0;
    exp2_out = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("div2_out_e%0d", i + 1), 32'(out2), 32'(exp2_out[i]));
      check($sformatf("div2_cnt_e%0d", i + 1), 32'(dut2.cnt), 32'd0);
    end

    // DIVISOR=8: rise on edge 4, then freeze mid-high with cnt=2.
    rst8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("div8_out_e%0d", i + 1), 32'(out8), (i == 3) ? 32'd1 : 32'd0);
    end
    step();
    step();
    check("div8_prefreeze_cnt", 32'(dut8.cnt), 32'd2);
    ce8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("div8_freeze_out_%0d", i), 32'(out8), 32'd1);
      check($sformatf("div8_freeze_cnt_%0d", i), 32'(dut8.cnt), 32'd2);
    end
    ce8 = 1'b1;
    step();
    check("div8_resume_out", 32'(out8), 32'd1);
    check("div8_resume_cnt", 32'(dut8.cnt), 32'd3);
    step();
    check("div8_fall_out", 32'(out8), 32'd0);
    check("div8_fall_cnt", 32'(dut8.cnt), 32'd0);

    // DIVISOR=6: run to out=1,cnt=2 then reset mid-period.
    rst6 = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("div6_pre_out", 32'(out6), 32'd1);
    check("div6_pre_cnt", 32'(dut6.cnt), 32'd2);
    rst6 = 1'b1;
    step();
    check("div6_rst_out", 32'(out6), 32'd0);
    check("div6_rst_cnt", 32'(dut6.cnt), 32'd0);
    rst6 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("div6_rel_out_e%0d", i + 1), 32'(out6), (i == 2) ? 32'd1 : 32'd0);
    end

    // Default DIVISOR: first rise after 25000 edges, fall after 50000.
    for (int i = 0; i < 60000 && big_fall < 0; i++) step();
    check("big_rise_edge", 32'(big_rise), 32'd25000);
    check("big_fall_edge", 32'(big_fall), 32'd50000);
    check("big_high_time", 32'(big_fall - big_rise), 32'd25000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
